load_store_unit: RTL
====================

# load_store_unit

Multi-cycle load/store unit between the decode/execute stage and the data bus. It consumes `rd_en`, `wr_en` and `mem_acc_mode` from the control unit, the ALU result as the effective address, and rs2 as store data. It runs a request/grant/response handshake on the data bus and stalls the core until the access completes. It returns sign- or zero-extended load data to the write-back mux.

## Interface
- `MAX_WAIT`, default 16: bus cycles allowed in REQ+WAIT before the access is aborted with a timeout.
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `rd_en`  in  1: load request from the control unit.
- `wr_en`  in  1: store request from the control unit.
- `mem_acc_mode`  in  3: access mode. 000 = byte, 001 = half, 010 = word, 011 = byte unsigned, 100 = half unsigned, 111 = none. 101 and 110 are treated as none.
- `addr`  in  32: effective address (ALU result).
- `wdata`  in  32: store data (rs2).
- `lsu_stall`  out  1: combinational; high means the core must hold PC and all inputs to this block.
- `load_data`  out  32: extended load result, valid in the DONE cycle.
- `misaligned`  out  1: one-cycle pulse on a misaligned access.
- `timeout_err`  out  1: one-cycle pulse in the DONE cycle of an aborted access.
- `dbus_req`  out  1: bus request.
- `dbus_we`  out  1: 1 = write.
- `dbus_addr`  out  32: word-aligned address, {addr[31:2], 2'b00}.
- `dbus_be`  out  4: byte enables.
- `dbus_wdata`  out  32: lane-replicated store data.
- `dbus_gnt`  in  1: request accepted.
- `dbus_rvalid`  in  1: response; read data valid or write acknowledged.
- `dbus_rdata`  in  32: read data.

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE, valid access: `wr_en` or `rd_en` is high and the mode is one of 000–100, with only 000–010 valid for stores.
  - `wr_en` has priority if both enables are high.
  - Latch `addr[1:0]`, mode, direction, `dbus_addr`, `dbus_be` and `dbus_wdata`.
  - `lsu_stall` = 1. Go to REQ.
- IDLE, enable with mode none, or a store with mode 011/100: no bus access, `lsu_stall` = 0.
- Alignment:
  - Misaligned means half with `addr[0]` = 1, or word with `addr[1:0]` ≠ 0.
  - On a misaligned access: `misaligned` = 1 and `lsu_stall` = 0 in the same cycle, no bus request, `load_data` = 0, stay in IDLE.
- REQ: `dbus_req` = 1 with stable address, byte enables, write data and write enable.
  - On `dbus_gnt`, go to WAIT.
  - `dbus_rvalid` seen in REQ is ignored.
- WAIT: `dbus_req` = 0.
  - On `dbus_rvalid`, register the formatted load data and go to DONE.
- DONE: `lsu_stall` = 0. `load_data` is held, and the core advances at this edge. Go to IDLE unconditionally.
- Timeout: a counter clears on entry to REQ and increments each cycle in REQ or WAIT.
  - When it reaches `MAX_WAIT`, go to DONE with `load_data` = 0 and `timeout_err` = 1.
  - A late `dbus_rvalid` arriving in IDLE or DONE is ignored.
- Store byte enables and data:
  - Byte: `dbus_be` = 0001 << `addr[1:0]`, `dbus_wdata` = {4{wdata[7:0]}}.
  - Half: `dbus_be` = 0011 << {`addr[1]`, 0}, `dbus_wdata` = {2{wdata[15:0]}}.
  - Word: `dbus_be` = 1111, `dbus_wdata` = `wdata`.
- Loads:
  - `dbus_be` is set exactly as for stores. `dbus_wdata` = 0.
  - The selected lane is `dbus_rdata` >> (8·`addr[1:0]`).
  - Byte and half are sign-extended for modes 000/001 and zero-extended for 011/100.
  - Word passes through unchanged.
  - Stores leave `load_data` at 0.

## Timing
- Reset (`rst` high at an edge): state = IDLE, counter = 0, and every registered output is 0 (`dbus_req`, `dbus_we`, `dbus_addr`, `dbus_be`, `dbus_wdata`, `load_data`, `timeout_err`).
- While `rst` is high, `lsu_stall` and `misaligned` are forced to 0.
- Reset mid-access: `dbus_req` drops after the reset edge. The access is abandoned with no DONE cycle.
- Minimum access, with `dbus_gnt` in the first REQ cycle and `dbus_rvalid` in the first WAIT cycle, by cycle:
  - C0 (IDLE): `lsu_stall` = 1.
  - C1 (REQ): `dbus_req` = 1, `lsu_stall` = 1.
  - C2 (WAIT): `lsu_stall` = 1.
  - C3 (DONE): `lsu_stall` = 0, `load_data` valid.
  - An aligned load/store therefore occupies 4 cycles. Each cycle of grant or response delay adds 1.
- Back-to-back accesses: the next instruction is evaluated in IDLE one cycle after DONE. There is no overlap.
- Timeout: DONE occurs at most `MAX_WAIT` + 2 cycles after C0.
- `misaligned` and `timeout_err` never both assert in the same cycle.

## Test plan
- LB at `addr` = 0x103 with `dbus_rdata` = 0x80112233, gnt and rvalid immediate:
  - `dbus_be` = 1000 in C1.
  - `load_data` = 0xFFFFFF80 in C3.
  - `lsu_stall` = 1 for C0–C2 only.
- LHU at 0x102 with rdata = 0xBEEF1234 → `load_data` = 0x0000BEEF. LH at the same address and data → `load_data` = 0xFFFFBEEF.
- SB of `wdata` = 0x000000A5 at 0x201, with gnt delayed by 3 cycles:
  - `dbus_be` = 0010, `dbus_wdata` = 0xA5A5A5A5, `dbus_we` = 1.
  - `dbus_req` holds for 4 cycles.
  - The access completes in 7 cycles.
- LW at 0x002 → `misaligned` pulse in C0, `lsu_stall` = 0, `dbus_req` never asserts. Mode 111 with `rd_en` = 1 → no request and no stall.
- LW granted with rvalid withheld, `MAX_WAIT` = 16 → DONE at C18 with `timeout_err` = 1 and `load_data` = 0. An rvalid arriving at C20 has no effect.
- `rst` asserted in WAIT → next cycle state = IDLE with all outputs 0. A following SW at 0x300 completes normally in 4 cycles with `dbus_be` = 1111.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: request/grant/response data-bus sequencer with
// lane steering, load extension, misalignment detection and timeout.
module load_store_unit #(
  parameter int MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [2:0]  mem_acc_mode,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        lsu_stall,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        timeout_err,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_gnt,
  input  logic        dbus_rvalid,
  input  logic [31:0] dbus_rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [1:0]    off;
  logic [2:0]    mode_q;

  logic        is_byte;
  logic        is_half;
  logic        is_word;
  logic        go;
  logic        mis;
  logic        idle;
  logic        timed_out;
  logic [3:0]  be_n;
  logic [31:0] wd_n;
  logic [31:0] lane;
  logic [31:0] fmt;

  always_comb begin
    is_byte = (mem_acc_mode == 3'b000) || (mem_acc_mode == 3'b011);
    is_half = (mem_acc_mode == 3'b001) || (mem_acc_mode == 3'b100);
    is_word = (mem_acc_mode == 3'b010);
    // stores only accept the three signed-encoded sizes
    if (wr_en) go = (mem_acc_mode <= 3'b010);
    else       go = rd_en && (is_byte || is_half || is_word);
    mis  = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));
    idle = (state == IDLE);
    misaligned = !rst && idle && go && mis;
    lsu_stall  = !rst && ((idle && go && !mis) ||
                 (state == REQ) || (state == WAIT));
    timed_out  = (cnt == CW'(MAX_WAIT));
  end

  always_comb begin
    be_n = 4'b1111;
    wd_n = wdata;
    if (is_byte) begin
      be_n = 4'b0001 << addr[1:0];
      wd_n = {4{wdata[7:0]}};
    end else if (is_half) begin
      be_n = addr[1] ? 4'b1100 : 4'b0011;
      wd_n = {2{wdata[15:0]}};
    end
    if (!wr_en) wd_n = 32'h0;
  end

  always_comb begin
    lane = dbus_rdata >> {off, 3'b000};
    unique case (mode_q)
      3'b000:  fmt = {{24{lane[7]}}, lane[7:0]};
      3'b011:  fmt = {24'h0, lane[7:0]};
      3'b001:  fmt = {{16{lane[15]}}, lane[15:0]};
      3'b100:  fmt = {16'h0, lane[15:0]};
      default: fmt = lane;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      off         <= 2'b00;
      mode_q      <= 3'b000;
      dbus_req    <= 1'b0;
      dbus_we     <= 1'b0;
      dbus_addr   <= 32'h0;
      dbus_be     <= 4'h0;
      dbus_wdata  <= 32'h0;
      load_data   <= 32'h0;
      timeout_err <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          load_data   <= 32'h0;
          timeout_err <= 1'b0;
          if (go && !mis) begin
            off        <= addr[1:0];
            mode_q     <= mem_acc_mode;
            dbus_we    <= wr_en;
            dbus_addr  <= {addr[31:2], 2'b00};
            dbus_be    <= be_n;
            dbus_wdata <= wd_n;
            dbus_req   <= 1'b1;
            cnt        <= '0;
            state      <= REQ;
          end
        end
        REQ: begin
          cnt <= cnt + CW'(1);
          if (timed_out) begin
            dbus_req    <= 1'b0;
            timeout_err <= 1'b1;
            load_data   <= 32'h0;
            state       <= DONE;
          end else if (dbus_gnt) begin
            dbus_req <= 1'b0;
            state    <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt + CW'(1);
          if (dbus_rvalid) begin
            load_data <= dbus_we ? 32'h0 : fmt;
            state     <= DONE;
          end else if (timed_out) begin
            timeout_err <= 1'b1;
            load_data   <= 32'h0;
            state       <= DONE;
          end
        end
        default: begin
          timeout_err <= 1'b0;
          load_data   <= 32'h0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule
